// File: rtl/select_n_one_pipe_if.sv
`default_nettype none
// ============================================================================
// Module  : select_n_one_pipe_if
// Brief   : Producer-side channels and consumer-side output of the N-way
//           registered selector, with valid/ready handshakes.
// Rev     : 1.0  initial release
// ============================================================================
interface select_n_one_pipe_if #(
  parameter int WIDTH = 32,
  parameter int N     = 4,
  parameter int SEL_W = 2
);
  logic [N*WIDTH-1:0] in_data;
  logic [N-1:0]       in_valid;
  logic [N-1:0]       in_ready;
  logic [SEL_W-1:0]   sel;
  logic [WIDTH-1:0]   out_data;
  logic [SEL_W-1:0]   out_chan;
  logic               out_valid;
  logic               out_ready;

  modport master (
    output in_data, in_valid, sel, out_ready,
    input  in_ready, out_data, out_chan, out_valid
  );

  modport slave (
    input  in_data, in_valid, sel, out_ready,
    output in_ready, out_data, out_chan, out_valid
  );
endinterface
`default_nettype wire

// File: rtl/select_n_one_pipe.sv
`default_nettype none
// ============================================================================
// Module  : select_n_one_pipe
// Brief   : N-way WIDTH-bit selector (explicit select or round-robin) with one
//           output pipeline register and valid/ready on every channel.
// Rev     : 1.0  initial release
// ============================================================================
module select_n_one_pipe #(
  parameter int WIDTH = 32,
  parameter int N     = 4,
  parameter int SEL_W = 2,
  parameter int MODE  = 0
) (
  input  wire logic          clk,
  input  wire logic          rst_n,
  select_n_one_pipe_if.slave bus
);

  localparam logic [SEL_W-1:0] c_last = SEL_W'(N - 1);

  logic [WIDTH-1:0] r_out_data;
  logic [SEL_W-1:0] r_out_chan;
  logic             r_out_valid;
  logic [SEL_W-1:0] r_rr_ptr;

  logic             w_load;
  logic             w_found_hi;
  logic             w_found_lo;
  logic [SEL_W-1:0] w_grant_hi;
  logic [SEL_W-1:0] w_grant_lo;
  logic             w_grant_vld;
  logic [SEL_W-1:0] w_idx;
  logic [N-1:0]     w_ready;
  logic [WIDTH-1:0] w_data;
  logic             w_acc;

  assign w_load = ~r_out_valid | bus.out_ready;

  // Two-pass scan: lowest valid at or above rr_ptr wins, else lowest valid overall (wrap).
  always_comb begin : p_grant
    w_found_hi = 1'b0;
    w_found_lo = 1'b0;
    w_grant_hi = '0;
    w_grant_lo = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (bus.in_valid[i]) begin
        w_found_lo = 1'b1;
        w_grant_lo = SEL_W'(i);
        if (SEL_W'(i) >= r_rr_ptr) begin
          w_found_hi = 1'b1;
          w_grant_hi = SEL_W'(i);
        end
      end
    end
  end

  always_comb begin : p_select
    w_grant_vld = 1'b0;
    w_idx       = '0;
    w_ready     = '0;
    w_data      = '0;
    if (MODE == 0) begin
      // An out-of-range sel matches no channel below, so nothing is offered.
      w_grant_vld = 1'b1;
      w_idx       = bus.sel;
    end else begin
      w_grant_vld = w_found_lo;
      w_idx       = w_found_hi ? w_grant_hi : w_grant_lo;
    end
    for (int i = 0; i < N; i++) begin
      if (SEL_W'(i) == w_idx) begin
        w_ready[i] = rst_n & w_load & w_grant_vld;
        w_data     = bus.in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  assign w_acc = |(w_ready & bus.in_valid);

  always_ff @(posedge clk or negedge rst_n) begin : p_out
    if (!rst_n) begin
      r_out_data  <= '0;
      r_out_chan  <= '0;
      r_out_valid <= 1'b0;
      r_rr_ptr    <= '0;
    end else if (w_acc) begin
      r_out_data  <= w_data;
      r_out_chan  <= w_idx;
      r_out_valid <= 1'b1;
      if (MODE != 0) begin
        r_rr_ptr <= (w_idx == c_last) ? '0 : w_idx + SEL_W'(1);
      end
    end else if (bus.out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign bus.in_ready  = w_ready;
  assign bus.out_data  = r_out_data;
  assign bus.out_chan  = r_out_chan;
  assign bus.out_valid = r_out_valid;

endmodule
`default_nettype wire

// File: tb/tb_select_n_one_pipe.sv
`default_nettype none
// ============================================================================
// Module  : tb_select_n_one_pipe
// Brief   : Directed and random checks of four selector configurations against
//           a cycle-level reference model of the selection rules.
// Rev     : 1.0  initial release
// ============================================================================
module tb_select_n_one_pipe;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;

  // u0: MODE0 N4 SEL_W2, u1: MODE1 N4, u2: MODE0 N4 SEL_W3, u3: MODE1 N3
  select_n_one_pipe_if #(.WIDTH(32), .N(4), .SEL_W(2)) b0 ();
  select_n_one_pipe_if #(.WIDTH(32), .N(4), .SEL_W(2)) b1 ();
  select_n_one_pipe_if #(.WIDTH(32), .N(4), .SEL_W(3)) b2 ();
  select_n_one_pipe_if #(.WIDTH(32), .N(3), .SEL_W(2)) b3 ();

  select_n_one_pipe #(.WIDTH(32), .N(4), .SEL_W(2), .MODE(0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(b0));
  select_n_one_pipe #(.WIDTH(32), .N(4), .SEL_W(2), .MODE(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1));
  select_n_one_pipe #(.WIDTH(32), .N(4), .SEL_W(3), .MODE(0)) dut2 (.clk(clk), .rst_n(rst_n), .bus(b2));
  select_n_one_pipe #(.WIDTH(32), .N(3), .SEL_W(2), .MODE(1)) dut3 (.clk(clk), .rst_n(rst_n), .bus(b3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state per DUT
  bit          mv[4];
  logic [31:0] md[4];
  int          mc[4];
  int          mp[4];

  function automatic int mode_of(input int u); return (u == 1 || u == 3) ? 1 : 0; endfunction
  function automatic int n_of(input int u);    return (u == 3) ? 3 : 4;           endfunction
  function automatic int selw_of(input int u); return (u == 2) ? 3 : 2;           endfunction

  function automatic int m_grant(input int u, input logic [3:0] v, input int s);
    int se;
    se = s % (1 << selw_of(u));
    if (mode_of(u) == 0) return (se < n_of(u)) ? se : -1;
    for (int k = 0; k < n_of(u); k++)
      if (v[(mp[u] + k) % n_of(u)]) return (mp[u] + k) % n_of(u);
    return -1;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic get_act(input int u, output logic [3:0] rdy, output logic ov,
                         output logic [31:0] od, output logic [2:0] oc);
    case (u)
      0:       begin rdy = b0.in_ready; ov = b0.out_valid; od = b0.out_data; oc = {1'b0, b0.out_chan}; end
      1:       begin rdy = b1.in_ready; ov = b1.out_valid; od = b1.out_data; oc = {1'b0, b1.out_chan}; end
      2:       begin rdy = b2.in_ready; ov = b2.out_valid; od = b2.out_data; oc = b2.out_chan;         end
      default: begin rdy = {1'b0, b3.in_ready}; ov = b3.out_valid; od = b3.out_data; oc = {1'b0, b3.out_chan}; end
    endcase
  endtask

  task automatic drive(input logic [127:0] d, input logic [3:0] v, input int s, input bit ordy);
    b0.in_data = d;        b0.in_valid = v;      b0.sel = 2'(s); b0.out_ready = ordy;
    b1.in_data = d;        b1.in_valid = v;      b1.sel = 2'(s); b1.out_ready = ordy;
    b2.in_data = d;        b2.in_valid = v;      b2.sel = 3'(s); b2.out_ready = ordy;
    b3.in_data = d[95:0];  b3.in_valid = v[2:0]; b3.sel = 2'(s); b3.out_ready = ordy;
  endtask

  task automatic check_out();
    logic [3:0] rdy; logic ov; logic [31:0] od; logic [2:0] oc;
    for (int u = 0; u < 4; u++) begin
      get_act(u, rdy, ov, od, oc);
      chk($sformatf("out_valid u%0d", u), 64'(ov), 64'(mv[u]));
      chk($sformatf("out_data u%0d", u),  64'(od), 64'(md[u]));
      chk($sformatf("out_chan u%0d", u),  64'(oc), 64'(mc[u]));
    end
  endtask

  // One clock of traffic: drive, check handshake, advance model, check registered outputs.
  task automatic cycle(input logic [127:0] d, input logic [3:0] v, input int s, input bit ordy);
    logic [3:0] rdy; logic ov; logic [31:0] od; logic [2:0] oc;
    logic [3:0] er; logic [3:0] vm; int g;
    drive(d, v, s, ordy);
    #1;
    for (int u = 0; u < 4; u++) begin
      g  = m_grant(u, v, s);
      er = ((!mv[u] || ordy) && g >= 0) ? 4'(1 << g) : 4'b0;
      vm = v & 4'((1 << n_of(u)) - 1);
      get_act(u, rdy, ov, od, oc);
      chk($sformatf("in_ready u%0d", u), 64'(rdy), 64'(er));
      if ((er & vm) != 4'b0) begin
        md[u] = d[g*32 +: 32];
        mc[u] = g;
        mv[u] = 1'b1;
        if (mode_of(u) == 1) mp[u] = (g + 1) % n_of(u);
      end else if (ordy) begin
        mv[u] = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    check_out();
  endtask

  // Asynchronous assertion mid-cycle with traffic still applied.
  task automatic do_reset();
    logic [3:0] rdy; logic ov; logic [31:0] od; logic [2:0] oc;
    #3;
    rst_n = 1'b0;
    #1;
    for (int u = 0; u < 4; u++) begin
      get_act(u, rdy, ov, od, oc);
      chk($sformatf("rst in_ready u%0d", u),  64'(rdy), 64'(0));
      chk($sformatf("rst out_valid u%0d", u), 64'(ov),  64'(0));
      chk($sformatf("rst out_data u%0d", u),  64'(od),  64'(0));
      chk($sformatf("rst out_chan u%0d", u),  64'(oc),  64'(0));
      mv[u] = 1'b0; md[u] = '0; mc[u] = 0; mp[u] = 0;
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  function automatic logic [127:0] mk(input logic [31:0] c0, input logic [31:0] c1,
                                      input logic [31:0] c2, input logic [31:0] c3);
    return {c3, c2, c1, c0};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] d;
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b1;
    drive('0, 4'b0, 0, 1'b0);
    @(posedge clk);
    #1;
    do_reset();

    // Explicit select of channel 2
    d = mk(32'h0, 32'h0, 32'hDEADBEEF, 32'h0);
    cycle(d, 4'b0100, 2, 1'b1);
    chk("T2 data", 64'(b0.out_data), 64'(32'hDEADBEEF));
    chk("T2 chan", 64'(b0.out_chan), 64'(2));
    chk("T2 valid", 64'(b0.out_valid), 64'(1));

    // Back-pressure holds the word and blocks channel 1
    d = mk(32'h0, 32'h11111111, 32'h0, 32'h0);
    for (int k = 0; k < 3; k++) begin
      cycle(d, 4'b0010, 1, 1'b0);
      chk("T3 held data", 64'(b0.out_data), 64'(32'hDEADBEEF));
      chk("T3 stall in_ready", 64'(b0.in_ready), 64'(0));
    end
    cycle(d, 4'b0010, 1, 1'b1);
    chk("T3 reload data", 64'(b0.out_data), 64'(32'h11111111));
    chk("T3 reload chan", 64'(b0.out_chan), 64'(1));

    // Round robin across all-valid channels; N=3 instance wraps 2->0
    do_reset();
    for (int k = 0; k < 8; k++) begin
      d = mk(32'hA0 + 32'(k), 32'hB0 + 32'(k), 32'hC0 + 32'(k), 32'hD0 + 32'(k));
      cycle(d, 4'b1111, 0, 1'b1);
      chk($sformatf("T4 rr4 chan k%0d", k), 64'(b1.out_chan), 64'(k % 4));
      chk($sformatf("T4 rr3 chan k%0d", k), 64'(b3.out_chan), 64'(k % 3));
      chk($sformatf("T4 rr4 valid k%0d", k), 64'(b1.out_valid), 64'(1));
    end

    // Pointer at 3 with channels 0 and 2 requesting
    do_reset();
    d = mk(32'h100, 32'h101, 32'h102, 32'h103);
    cycle(d, 4'b0100, 0, 1'b1);
    cycle(d, 4'b0101, 0, 1'b1);
    chk("T5 first grant", 64'(b1.out_chan), 64'(0));
    cycle(d, 4'b0101, 0, 1'b1);
    chk("T5 second grant", 64'(b1.out_chan), 64'(2));
    cycle(d, 4'b1001, 0, 1'b1);
    chk("T5 ptr back at 3", 64'(b1.out_chan), 64'(3));

    // Out-of-range select on the 3-bit select instance
    do_reset();
    for (int k = 0; k < 4; k++) begin
      cycle(d, 4'b1111, 5, 1'b1);
      chk("T6 sel5 in_ready", 64'(b2.in_ready), 64'(0));
      chk("T6 sel5 out_valid", 64'(b2.out_valid), 64'(0));
    end

    // Random traffic
    for (int k = 0; k < 300; k++) begin
      d = {$urandom, $urandom, $urandom, $urandom};
      cycle(d, 4'($urandom), int'($urandom_range(0, 7)), ($urandom_range(0, 9) < 7));
    end

    // Reset in the middle of random traffic, then resume
    do_reset();
    for (int k = 0; k < 20; k++) begin
      d = {$urandom, $urandom, $urandom, $urandom};
      cycle(d, 4'($urandom), int'($urandom_range(0, 7)), ($urandom_range(0, 3) != 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
